// File: rtl/game_pkg.sv
// game_pkg: cell/result codes, FSM states and line-scan direction steps for board_game_engine
package game_pkg;
  localparam logic [1:0] EMPTY = 2'b00, X = 2'b01, O = 2'b10;
  localparam logic [1:0] NONE = 2'b00, XWIN = 2'b01, OWIN = 2'b10, DRAW = 2'b11;
  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;
  // row, column, diagonal, anti-diagonal
  localparam int DR [4] = '{0, 1, 1, 1};
  localparam int DC [4] = '{1, 0, 1, -1};
endpackage

// File: rtl/line_scan.sv
// line_scan: run length of one player's code through a cell along one direction
module line_scan
  import game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int CW = $clog2(N),
  localparam int RW = $clog2(2*K)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [CW-1:0]    row,
  input  logic [CW-1:0]    col,
  input  logic [1:0]       dir,
  input  logic [1:0]       code,
  output logic [RW-1:0]    run
);
  function automatic logic match(input int r, input int c);
    logic ok;
    int idx;
    ok = r >= 0 && r < N && c >= 0 && c < N;
    idx = ok ? 2*(r*N + c) : 0;
    return ok && board[idx +: 2] == code;
  endfunction
  always_comb begin
    logic f, b;
    int n;
    f = 1'b1;
    b = 1'b1;
    n = 1;
    for (int i = 1; i < K; i++) begin
      f = f && match(int'(row) + i*DR[dir], int'(col) + i*DC[dir]);
      b = b && match(int'(row) - i*DR[dir], int'(col) - i*DC[dir]);
      n = n + int'(f) + int'(b);
    end
    run = RW'(n);
  end
endmodule

// File: rtl/board_game_engine.sv
// board_game_engine: N x N, K-in-a-row two-player engine with a 4-cycle sequential win/draw check
module board_game_engine
  import game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  parameter int ALT_START = 0,
  localparam int CW = $clog2(N),
  localparam int MW = $clog2(N*N+1),
  localparam int RW = $clog2(2*K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [CW-1:0]    move_row,
  input  logic [CW-1:0]    move_col,
  output logic             move_ready,
  output logic             move_accept,
  output logic             move_reject,
  output logic [2*N*N-1:0] board,
  output logic             cur_player,
  output logic [1:0]       result,
  output logic [MW-1:0]    move_count
);
  state_t state;
  logic [1:0] d;
  logic [CW-1:0] last_r, last_c;
  logic win, start_tog, in_range, legal, hit;
  logic [1:0] code;
  logic [RW-1:0] run;
  int idx;
  assign move_ready = state == IDLE;
  assign code = cur_player ? O : X;
  assign in_range = int'(move_row) < N && int'(move_col) < N;
  assign idx = in_range ? 2*(int'(move_row)*N + int'(move_col)) : 0;
  assign legal = in_range && board[idx +: 2] == EMPTY;
  assign hit = win || int'(run) >= K;
  line_scan #(.N(N), .K(K)) scan (
    .board(board), .row(last_r), .col(last_c), .dir(d), .code(code), .run(run)
  );
  always_ff @(posedge clk) begin
    move_accept <= 1'b0;
    move_reject <= 1'b0;
    if (!reset) begin
      state <= IDLE;
      board <= '0;
      cur_player <= 1'b0;
      result <= NONE;
      move_count <= '0;
      start_tog <= 1'b0;
      d <= 2'd0;
      win <= 1'b0;
      last_r <= '0;
      last_c <= '0;
    end else if (new_game) begin
      state <= IDLE;
      board <= '0;
      result <= NONE;
      move_count <= '0;
      start_tog <= (ALT_START != 0) && !start_tog;
      cur_player <= (ALT_START != 0) && !start_tog;
    end else if (state == IDLE && move_valid) begin
      if (legal) begin
        board[idx +: 2] <= code;
        move_accept <= 1'b1;
        move_count <= move_count + 1'b1;
        last_r <= move_row;
        last_c <= move_col;
        d <= 2'd0;
        win <= 1'b0;
        state <= CHECK;
      end else begin
        move_reject <= 1'b1;
      end
    end else if (state == CHECK) begin
      d <= d + 2'd1;
      win <= hit;
      if (d == 2'd3) begin
        if (hit) begin
          result <= cur_player ? OWIN : XWIN;
          state <= OVER;
        end else if (int'(move_count) == N*N) begin
          result <= DRAW;
          state <= OVER;
        end else begin
          cur_player <= !cur_player;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_board_game_engine.sv
// tb_board_game_engine: two engines (3x3 fixed start, 4x4 K=3 alternating start) against a board-scanning model
module tb_board_game_engine;
  logic clk = 1'b0, reset = 1'b0, new_game = 1'b0, move_valid = 1'b0;
  logic [1:0] move_row = '0, move_col = '0;
  always #5 clk = ~clk;
  logic rdy0, acc0, rej0, cp0, rdy1, acc1, rej1, cp1;
  logic [17:0] board0;
  logic [31:0] board1;
  logic [1:0] res0, res1;
  logic [3:0] cnt0;
  logic [4:0] cnt1;
  board_game_engine #(.N(3), .K(3), .ALT_START(0)) dut0 (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_row(move_row), .move_col(move_col), .move_ready(rdy0), .move_accept(acc0),
    .move_reject(rej0), .board(board0), .cur_player(cp0), .result(res0), .move_count(cnt0)
  );
  board_game_engine #(.N(4), .K(3), .ALT_START(1)) dut1 (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_row(move_row), .move_col(move_col), .move_ready(rdy1), .move_accept(acc1),
    .move_reject(rej1), .board(board1), .cur_player(cp1), .result(res1), .move_count(cnt1)
  );
  logic [63:0] ob [2];
  logic [4:0] ocnt [2];
  logic [1:0] ores [2];
  logic ordy [2], oacc [2], orej [2], ocp [2];
  assign ob[0] = 64'(board0);
  assign ob[1] = 64'(board1);
  assign ocnt[0] = 5'(cnt0);
  assign ocnt[1] = cnt1;
  assign ores[0] = res0;
  assign ores[1] = res1;
  assign ordy[0] = rdy0;
  assign ordy[1] = rdy1;
  assign oacc[0] = acc0;
  assign oacc[1] = acc1;
  assign orej[0] = rej0;
  assign orej[1] = rej1;
  assign ocp[0] = cp0;
  assign ocp[1] = cp1;

  int mn [2] = '{3, 4};
  int mk [2] = '{3, 3};
  int malt [2] = '{0, 1};
  int mb [2][8][8];
  int mp [2], mres [2], mcnt [2], mtog [2];
  int tests = 0, fails = 0;

  function automatic bit m_has_line(input int i, input int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < mn[i]; r++)
      for (int c = 0; c < mn[i]; c++)
        for (int d = 0; d < 4; d++) begin
          int run = 0;
          for (int s = 0; s < mk[i]; s++) begin
            int rr = r + s*dr[d];
            int cc = c + s*dc[d];
            if (rr >= 0 && rr < mn[i] && cc >= 0 && cc < mn[i] && mb[i][rr][cc] == p) run++;
          end
          if (run == mk[i]) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_board(input int i);
    logic [63:0] v = '0;
    for (int r = 0; r < mn[i]; r++)
      for (int c = 0; c < mn[i]; c++) v[2*(r*mn[i]+c) +: 2] = 2'(mb[i][r][c]);
    return v;
  endfunction

  function automatic logic [74:0] got_t(input int i);
    return {ob[i], ocnt[i], ores[i], ocp[i], ordy[i], oacc[i], orej[i]};
  endfunction

  function automatic logic [74:0] exp_t(input int i, input int cp, input int res,
                                        input bit rdy, input bit acc, input bit rej);
    return {m_board(i), 5'(mcnt[i]), 2'(res), 1'(cp), rdy, acc, rej};
  endfunction

  task automatic m_clear(input int i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[i][r][c] = 0;
    mres[i] = 0;
    mcnt[i] = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_clear(i);
      mp[i] = 0;
      mtog[i] = 0;
    end
  endtask

  task automatic m_new_game();
    for (int i = 0; i < 2; i++) begin
      m_clear(i);
      if (malt[i] != 0) mtog[i] ^= 1;
      mp[i] = malt[i] != 0 ? mtog[i] : 0;
    end
  endtask

  // kind: 0 ignored (game over), 1 rejected, 2 accepted
  task automatic m_move(input int i, input int r, input int c, output int kind);
    if (mres[i] != 0) kind = 0;
    else if (r >= mn[i] || c >= mn[i] || mb[i][r][c] != 0) kind = 1;
    else begin
      kind = 2;
      mb[i][r][c] = mp[i] + 1;
      mcnt[i]++;
      if (m_has_line(i, mp[i] + 1)) mres[i] = mp[i] + 1;
      else if (mcnt[i] == mn[i]*mn[i]) mres[i] = 3;
      else mp[i] ^= 1;
    end
  endtask

  task automatic do_move(input int r, input int c, input string tag);
    int kind [2], oldp [2];
    logic [74:0] e;
    move_valid = 1'b1;
    move_row = 2'(r);
    move_col = 2'(c);
    for (int i = 0; i < 2; i++) begin
      oldp[i] = mp[i];
      m_move(i, r, c, kind[i]);
    end
    @(posedge clk);
    #1 move_valid = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 2; i++) begin
        e = exp_t(i, (kind[i] == 2 && j < 4) ? oldp[i] : mp[i],
                  (kind[i] == 2 && j < 4) ? 0 : mres[i],
                  kind[i] == 1 || (kind[i] == 2 && j == 4 && mres[i] == 0),
                  j == 0 && kind[i] == 2, j == 0 && kind[i] == 1);
        tests++;
        if (got_t(i) !== e) begin
          fails++;
          $display("FAIL %s dut%0d cyc%0d: got %h expected %h", tag, i, j, got_t(i), e);
        end
      end
    end
  endtask

  task automatic do_new_game(input string tag);
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    m_new_game();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_t(i) !== exp_t(i, mp[i], 0, 1'b1, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL %s dut%0d: got %h expected %h", tag, i, got_t(i), exp_t(i, mp[i], 0, 1'b1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_t(i) !== exp_t(i, 0, 0, 1'b1, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL reset dut%0d: got %h expected %h", i, got_t(i), exp_t(i, 0, 0, 1'b1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_x_wins_row();
    int mv [5][2] = '{'{0, 0}, '{1, 0}, '{0, 1}, '{1, 1}, '{0, 2}};
    for (int m = 0; m < 5; m++) do_move(mv[m][0], mv[m][1], "xwin");
    tests++;
    if (res0 !== 2'b01 || res1 !== 2'b01 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      fails++;
      $display("FAIL xwin_result: got res %b/%b rdy %b/%b expected 01/01 0/0", res0, res1, rdy0, rdy1);
    end
    do_move(2, 2, "over_ignored");
  endtask

  task automatic test_reject_occupied();
    do_new_game("ng_reject");
    do_move(1, 1, "first");
    do_move(1, 1, "occupied");
    tests++;
    if (cp0 !== 1'b1 || cnt0 !== 4'd1) begin
      fails++;
      $display("FAIL occupied_state: got cp %b cnt %0d expected cp 1 cnt 1", cp0, cnt0);
    end
  endtask

  task automatic test_draw();
    int mv [9][2] = '{'{0, 0}, '{0, 1}, '{0, 2}, '{1, 1}, '{1, 0}, '{1, 2}, '{2, 1}, '{2, 0}, '{2, 2}};
    do_new_game("ng_draw");
    for (int m = 0; m < 9; m++) do_move(mv[m][0], mv[m][1], "draw");
    tests++;
    if (res0 !== 2'b11 || cnt0 !== 4'd9) begin
      fails++;
      $display("FAIL draw_result: got res %b cnt %0d expected 11 cnt 9", res0, cnt0);
    end
  endtask

  task automatic test_anti_diag();
    int mv [5][2] = '{'{1, 2}, '{0, 0}, '{2, 1}, '{0, 1}, '{3, 0}};
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    for (int m = 0; m < 5; m++) do_move(mv[m][0], mv[m][1], "antidiag");
    tests++;
    if (res1 !== 2'b01 || res0 !== 2'b00) begin
      fails++;
      $display("FAIL antidiag_result: got %b/%b expected 00/01", res0, res1);
    end
  endtask

  task automatic test_alt_start();
    do_new_game("alt1");
    tests++;
    if (cp1 !== 1'b1 || cp0 !== 1'b0) begin
      fails++;
      $display("FAIL alt_start1: got cp %b/%b expected 0/1", cp0, cp1);
    end
    do_new_game("alt2");
    tests++;
    if (cp1 !== 1'b0) begin
      fails++;
      $display("FAIL alt_start2: got cp1 %b expected 0", cp1);
    end
  endtask

  task automatic test_new_game_mid_check();
    int kind;
    move_valid = 1'b1;
    move_row = 2'd0;
    move_col = 2'd0;
    for (int i = 0; i < 2; i++) m_move(i, 0, 0, kind);
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #1 new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    m_new_game();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_t(i) !== exp_t(i, mp[i], 0, 1'b1, 1'b0, 1'b0)) begin
          fails++;
          $display("FAIL abort_check dut%0d cyc%0d: got %h expected %h", i, j, got_t(i), exp_t(i, mp[i], 0, 1'b1, 1'b0, 1'b0));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_new_game_with_handshake();
    move_valid = 1'b1;
    new_game = 1'b1;
    move_row = 2'd1;
    move_col = 2'd1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    new_game = 1'b0;
    m_new_game();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_t(i) !== exp_t(i, mp[i], 0, 1'b1, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL ng_and_move dut%0d: got %h expected %h", i, got_t(i), exp_t(i, mp[i], 0, 1'b1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_reset_during_check();
    move_valid = 1'b1;
    move_row = 2'd2;
    move_col = 2'd2;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_t(i) !== exp_t(i, 0, 0, 1'b1, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL reset_in_check dut%0d: got %h expected %h", i, got_t(i), exp_t(i, 0, 0, 1'b1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    do_new_game("rand_ng");
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 13) == 0) do_new_game("rand_ng");
      else do_move(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_x_wins_row();
    test_reject_occupied();
    test_draw();
    test_anti_diag();
    test_alt_start();
    test_new_game_mid_check();
    test_new_game_with_handshake();
    test_reset_during_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
